// File: rtl/tx_fire_sequencer_if.sv
// Signal bundle between the output control logic and the transducer fire
// engine. The slave modport is the engine's view and the master modport is
// the controller's view. Signal names match the legacy flat port list.
//   itxArm/itxMask/itxPhaseDelay/itxChargeTime/itxBurstCount/itxPulsePeriod
//     carry the arm request and the fire configuration.
//   itxTrigger carries the fire trigger, and itxAbort the synchronous abort.
//   otxTransducerOutput drives the transducer pins.
//   otxArmed, otxBusy, otxFireComplete, otxError and otxErrorCode report status.
interface tx_fire_sequencer_if #(
  parameter int unsigned NCH      = 8,
  parameter int unsigned PHASE_W  = 16,
  parameter int unsigned CHARGE_W = 9,
  parameter int unsigned BURST_W  = 8,
  parameter int unsigned PERIOD_W = 16
);
  logic                     itxArm;
  logic [NCH-1:0]           itxMask;
  logic [NCH*PHASE_W-1:0]   itxPhaseDelay;
  logic [CHARGE_W-1:0]      itxChargeTime;
  logic [BURST_W-1:0]       itxBurstCount;
  logic [PERIOD_W-1:0]      itxPulsePeriod;
  logic                     itxTrigger;
  logic                     itxAbort;
  logic [NCH-1:0]           otxTransducerOutput;
  logic                     otxArmed;
  logic                     otxBusy;
  logic                     otxFireComplete;
  logic                     otxError;
  logic [1:0]               otxErrorCode;

  modport slave (
    input  itxArm, itxMask, itxPhaseDelay, itxChargeTime, itxBurstCount,
           itxPulsePeriod, itxTrigger, itxAbort,
    output otxTransducerOutput, otxArmed, otxBusy, otxFireComplete,
           otxError, otxErrorCode
  );

  modport master (
    output itxArm, itxMask, itxPhaseDelay, itxChargeTime, itxBurstCount,
           itxPulsePeriod, itxTrigger, itxAbort,
    input  otxTransducerOutput, otxArmed, otxBusy, otxFireComplete,
           otxError, otxErrorCode
  );
endinterface

// File: rtl/tx_fire_sequencer.sv
// Multi-channel transducer fire engine.
// An arm request validates the configuration and latches it into shadow
// registers. The next rising edge of the trigger then starts a burst of
// phase-delayed charge pulses on every enabled channel. A watchdog bounds the
// time spent firing, and an abort returns the engine to idle at any point.
// Ports:
//   txCLK   system clock
//   txRSTn  asynchronous active-low reset
//   bus     slave side of tx_fire_sequencer_if (configuration, trigger and
//           abort inputs; drive outputs and status outputs)
module tx_fire_sequencer #(
  parameter int unsigned NCH      = 8,
  parameter int unsigned PHASE_W  = 16,
  parameter int unsigned CHARGE_W = 9,
  parameter int unsigned BURST_W  = 8,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned MAX_ON   = 400,
  parameter int unsigned WDOG     = 1 << 20
) (
  input  logic                  txCLK,
  input  logic                  txRSTn,
  tx_fire_sequencer_if.slave    bus
);

  localparam int unsigned CNT_A = (PHASE_W > PERIOD_W) ? PHASE_W : PERIOD_W;
  localparam int unsigned CNT_W = (CNT_A > CHARGE_W) ? CNT_A : CHARGE_W;
  localparam int unsigned WD_W  = $clog2(WDOG + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FIRING} state_e;
  typedef enum logic [1:0] {CH_DONE, CH_DELAY, CH_CHARGE, CH_GAP} ch_state_e;

  state_e                 state_q, state_d;
  logic                   trig_prev_q, trig_prev_d;
  logic [NCH-1:0]         sh_mask_q, sh_mask_d;
  logic [NCH*PHASE_W-1:0] sh_phase_q, sh_phase_d;
  logic [CHARGE_W-1:0]    sh_charge_q, sh_charge_d;
  logic [BURST_W-1:0]     sh_burst_q, sh_burst_d;
  logic [PERIOD_W-1:0]    sh_period_q, sh_period_d;
  ch_state_e              ch_st_q   [NCH];
  ch_state_e              ch_st_d   [NCH];
  logic [CNT_W-1:0]       ch_cnt_q  [NCH];
  logic [CNT_W-1:0]       ch_cnt_d  [NCH];
  logic [BURST_W-1:0]     ch_left_q [NCH];
  logic [BURST_W-1:0]     ch_left_d [NCH];
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [NCH-1:0]         out_q, out_d;
  logic                   armed_q, armed_d;
  logic                   busy_q, busy_d;
  logic                   complete_q, complete_d;
  logic                   err_q, err_d;
  logic [1:0]             code_q, code_d;

  logic                   trig_edge;
  logic                   cfg_bad;
  logic                   all_done;
  logic [CNT_W:0]         charge_x, period_x, p_eff;
  logic [CNT_W-1:0]       charge_m1, gap_m1;
  logic [BURST_W-1:0]     burst_m1;

  // Pulse timing derived from the shadow configuration. The gap is the low
  // time between pulses, so each rising edge is P_eff cycles after the last.
  always_comb begin
    charge_x  = (CNT_W+1)'(sh_charge_q);
    period_x  = (CNT_W+1)'(sh_period_q);
    p_eff     = (period_x > charge_x) ? period_x : charge_x + 1'b1;
    charge_m1 = CNT_W'(charge_x - 1'b1);
    gap_m1    = CNT_W'(p_eff - charge_x - 1'b1);
    burst_m1  = (sh_burst_q == '0) ? '0 : sh_burst_q - 1'b1;
  end

  always_comb begin
    trig_edge = bus.itxTrigger & ~trig_prev_q;
    cfg_bad   = (bus.itxMask == '0) || (bus.itxChargeTime == '0) ||
                (32'(bus.itxChargeTime) > MAX_ON);

    state_d     = state_q;
    trig_prev_d = bus.itxTrigger;
    sh_mask_d   = sh_mask_q;
    sh_phase_d  = sh_phase_q;
    sh_charge_d = sh_charge_q;
    sh_burst_d  = sh_burst_q;
    sh_period_d = sh_period_q;
    wd_d        = wd_q;
    out_d       = out_q;
    complete_d  = 1'b0;
    err_d       = err_q;
    code_d      = code_q;
    all_done    = 1'b1;
    for (int unsigned k = 0; k < NCH; k++) begin
      ch_st_d[k]   = ch_st_q[k];
      ch_cnt_d[k]  = ch_cnt_q[k];
      ch_left_d[k] = ch_left_q[k];
    end

    if (bus.itxAbort) begin
      state_d   = S_IDLE;
      out_d     = '0;
      sh_mask_d = '0;
      for (int unsigned k = 0; k < NCH; k++) ch_st_d[k] = CH_DONE;
    end else begin
      case (state_q)
        S_IDLE, S_ARMED: begin
          if (bus.itxArm) begin
            if (cfg_bad) begin
              state_d = S_IDLE;
              err_d   = 1'b1;
              code_d  = 2'b01;
            end else begin
              state_d     = S_ARMED;
              sh_mask_d   = bus.itxMask;
              sh_phase_d  = bus.itxPhaseDelay;
              sh_charge_d = bus.itxChargeTime;
              sh_burst_d  = bus.itxBurstCount;
              sh_period_d = bus.itxPulsePeriod;
              err_d       = 1'b0;
              code_d      = 2'b00;
            end
          end else if ((state_q == S_ARMED) && trig_edge) begin
            state_d = S_FIRING;
            wd_d    = '0;
            // A zero phase delay must drive the pin on the first FIRING cycle,
            // so such channels enter CHARGE directly at the trigger.
            for (int unsigned k = 0; k < NCH; k++) begin
              ch_left_d[k] = burst_m1;
              out_d[k]     = 1'b0;
              if (!sh_mask_q[k]) begin
                ch_st_d[k] = CH_DONE;
              end else if (sh_phase_q[k*PHASE_W +: PHASE_W] == '0) begin
                ch_st_d[k]  = CH_CHARGE;
                ch_cnt_d[k] = charge_m1;
                out_d[k]    = 1'b1;
              end else begin
                ch_st_d[k]  = CH_DELAY;
                ch_cnt_d[k] = CNT_W'(sh_phase_q[k*PHASE_W +: PHASE_W]) - 1'b1;
              end
            end
          end
        end

        S_FIRING: begin
          // Each counter holds the cycles remaining in its segment after the
          // current one, so a segment ends when its counter is zero.
          for (int unsigned k = 0; k < NCH; k++) begin
            case (ch_st_q[k])
              CH_DELAY: begin
                if (ch_cnt_q[k] == '0) begin
                  ch_st_d[k]  = CH_CHARGE;
                  ch_cnt_d[k] = charge_m1;
                  out_d[k]    = 1'b1;
                end else begin
                  ch_cnt_d[k] = ch_cnt_q[k] - 1'b1;
                end
              end
              CH_CHARGE: begin
                if (ch_cnt_q[k] == '0) begin
                  out_d[k] = 1'b0;
                  if (ch_left_q[k] == '0) begin
                    ch_st_d[k] = CH_DONE;
                  end else begin
                    ch_st_d[k]  = CH_GAP;
                    ch_cnt_d[k] = gap_m1;
                  end
                end else begin
                  ch_cnt_d[k] = ch_cnt_q[k] - 1'b1;
                end
              end
              CH_GAP: begin
                if (ch_cnt_q[k] == '0) begin
                  ch_st_d[k]   = CH_CHARGE;
                  ch_cnt_d[k]  = charge_m1;
                  ch_left_d[k] = ch_left_q[k] - 1'b1;
                  out_d[k]     = 1'b1;
                end else begin
                  ch_cnt_d[k] = ch_cnt_q[k] - 1'b1;
                end
              end
              default: out_d[k] = 1'b0;
            endcase
            if (ch_st_d[k] != CH_DONE) all_done = 1'b0;
          end

          if (wd_q == WD_W'(WDOG - 1)) begin
            state_d = S_IDLE;
            out_d   = '0;
            err_d   = 1'b1;
            code_d  = 2'b10;
            for (int unsigned k = 0; k < NCH; k++) ch_st_d[k] = CH_DONE;
          end else if (all_done) begin
            state_d    = S_IDLE;
            out_d      = '0;
            complete_d = 1'b1;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    armed_d = (state_d == S_ARMED);
    busy_d  = (state_d == S_FIRING);
  end

  always_ff @(posedge txCLK or negedge txRSTn) begin
    if (!txRSTn) begin
      state_q     <= S_IDLE;
      trig_prev_q <= 1'b0;
      sh_mask_q   <= '0;
      sh_phase_q  <= '0;
      sh_charge_q <= '0;
      sh_burst_q  <= '0;
      sh_period_q <= '0;
      wd_q        <= '0;
      out_q       <= '0;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      complete_q  <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 2'b00;
      for (int unsigned k = 0; k < NCH; k++) begin
        ch_st_q[k]   <= CH_DONE;
        ch_cnt_q[k]  <= '0;
        ch_left_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      trig_prev_q <= trig_prev_d;
      sh_mask_q   <= sh_mask_d;
      sh_phase_q  <= sh_phase_d;
      sh_charge_q <= sh_charge_d;
      sh_burst_q  <= sh_burst_d;
      sh_period_q <= sh_period_d;
      wd_q        <= wd_d;
      out_q       <= out_d;
      armed_q     <= armed_d;
      busy_q      <= busy_d;
      complete_q  <= complete_d;
      err_q       <= err_d;
      code_q      <= code_d;
      for (int unsigned k = 0; k < NCH; k++) begin
        ch_st_q[k]   <= ch_st_d[k];
        ch_cnt_q[k]  <= ch_cnt_d[k];
        ch_left_q[k] <= ch_left_d[k];
      end
    end
  end

  assign bus.otxTransducerOutput = out_q;
  assign bus.otxArmed            = armed_q;
  assign bus.otxBusy             = busy_q;
  assign bus.otxFireComplete     = complete_q;
  assign bus.otxError            = err_q;
  assign bus.otxErrorCode        = code_q;

endmodule

// File: tb/tb_tx_fire_sequencer.sv
// Self-checking bench for tx_fire_sequencer. Expected drive waveforms are
// computed directly from each channel's phase, pulse period, charge time and
// burst length.
module tb_tx_fire_sequencer;
  localparam int unsigned NCH      = 8;
  localparam int unsigned PHASE_W  = 16;
  localparam int unsigned CHARGE_W = 9;
  localparam int unsigned BURST_W  = 8;
  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned MAX_ON   = 400;
  localparam int unsigned WDOG     = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tx_fire_sequencer_if #(.NCH(NCH), .PHASE_W(PHASE_W), .CHARGE_W(CHARGE_W),
                         .BURST_W(BURST_W), .PERIOD_W(PERIOD_W)) bus ();

  tx_fire_sequencer #(.NCH(NCH), .PHASE_W(PHASE_W), .CHARGE_W(CHARGE_W),
                      .BURST_W(BURST_W), .PERIOD_W(PERIOD_W),
                      .MAX_ON(MAX_ON), .WDOG(WDOG)) dut (
    .txCLK  (clk),
    .txRSTn (rst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [NCH-1:0] m;
  int ph [NCH];
  int chg, bst, per;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg();
    bus.itxMask = m;
    for (int k = 0; k < NCH; k++) bus.itxPhaseDelay[k*PHASE_W +: PHASE_W] = PHASE_W'(ph[k]);
    bus.itxChargeTime  = CHARGE_W'(chg);
    bus.itxBurstCount  = BURST_W'(bst);
    bus.itxPulsePeriod = PERIOD_W'(per);
  endtask

  function automatic int eff_period();
    return (per > chg) ? per : chg + 1;
  endfunction

  function automatic int eff_burst();
    return (bst == 0) ? 1 : bst;
  endfunction

  // Drive level of every channel t cycles after the trigger-edge cycle.
  function automatic logic [NCH-1:0] model_out(input int t);
    logic [NCH-1:0] r;
    int pe;
    int b;
    r  = '0;
    pe = eff_period();
    b  = eff_burst();
    for (int k = 0; k < NCH; k++) begin
      int d;
      d = t - 1 - ph[k];
      if (m[k] && d >= 0 && (d / pe) < b && (d % pe) < chg) r[k] = 1'b1;
    end
    return r;
  endfunction

  // Offset of the last high cycle of the last pulse over all enabled channels.
  function automatic int last_end();
    int e;
    e = 0;
    for (int k = 0; k < NCH; k++)
      if (m[k] && ph[k] + (eff_burst() - 1) * eff_period() + chg > e)
        e = ph[k] + (eff_burst() - 1) * eff_period() + chg;
    return e;
  endfunction

  task automatic arm_cfg(input bit ok);
    set_cfg();
    bus.itxArm = 1'b1;
    tick();
    bus.itxArm = 1'b0;
    check("armed_after_arm", 32'(bus.otxArmed), 32'(ok));
    check("err_after_arm", 32'(bus.otxError), ok ? 32'd0 : 32'd1);
    check("code_after_arm", 32'(bus.otxErrorCode), ok ? 32'd0 : 32'd1);
  endtask

  // Expects the DUT armed with the current configuration and itxTrigger low in
  // the previous cycle. abort_at > 0 raises itxAbort during that cycle.
  task automatic fire(input int abort_at, input bit trig_toggle);
    int tc;
    int end_t;
    int kind;  // 0 complete, 1 watchdog, 2 abort
    tc    = last_end() + 1;
    end_t = tc;
    kind  = 0;
    if (WDOG + 1 <= end_t) begin end_t = WDOG + 1; kind = 1; end
    if (abort_at > 0 && abort_at + 1 <= end_t) begin end_t = abort_at + 1; kind = 2; end
    bus.itxTrigger = 1'b1;
    tick();
    for (int t = 1; t <= end_t + 2; t++) begin
      check("out", 32'(bus.otxTransducerOutput), (t < end_t) ? 32'(model_out(t)) : 32'd0);
      check("busy", 32'(bus.otxBusy), 32'(t < end_t));
      check("complete", 32'(bus.otxFireComplete), 32'(kind == 0 && t == end_t));
      check("armed_firing", 32'(bus.otxArmed), 32'd0);
      if (t == end_t) begin
        check("err_end", 32'(bus.otxError), (kind == 1) ? 32'd1 : 32'd0);
        check("code_end", 32'(bus.otxErrorCode), (kind == 1) ? 32'd2 : 32'd0);
      end
      bus.itxAbort   = (t == abort_at);
      bus.itxTrigger = trig_toggle ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    bus.itxAbort   = 1'b0;
    bus.itxTrigger = 1'b0;
    tick();
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.itxArm         = 1'b0;
    bus.itxMask        = '0;
    bus.itxPhaseDelay  = '0;
    bus.itxChargeTime  = '0;
    bus.itxBurstCount  = '0;
    bus.itxPulsePeriod = '0;
    bus.itxTrigger     = 1'b0;
    bus.itxAbort       = 1'b0;
    tick();
    tick();
    check("rst_out", 32'(bus.otxTransducerOutput), 32'd0);
    check("rst_armed", 32'(bus.otxArmed), 32'd0);
    check("rst_busy", 32'(bus.otxBusy), 32'd0);
    check("rst_complete", 32'(bus.otxFireComplete), 32'd0);
    check("rst_err", 32'(bus.otxError), 32'd0);
    check("rst_code", 32'(bus.otxErrorCode), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single shot, staggered phases.
    m = 8'hFF; chg = 10; bst = 1; per = 0;
    for (int k = 0; k < NCH; k++) ph[k] = 3 * k;
    arm_cfg(1'b1);
    fire(0, 1'b0);

    // Burst on one channel.
    m = 8'h01; chg = 4; bst = 3; per = 10;
    for (int k = 0; k < NCH; k++) ph[k] = 0;
    arm_cfg(1'b1);
    fire(0, 1'b0);

    // Period shorter than charge time, partial mask.
    m = 8'h05; chg = 5; bst = 2; per = 3;
    for (int k = 0; k < NCH; k++) ph[k] = k + 1;
    ph[0] = 0;
    arm_cfg(1'b1);
    fire(0, 1'b1);

    // Config rejects; trigger edge afterwards must not fire.
    m = 8'h01; chg = 0; arm_cfg(1'b0);
    chg = MAX_ON + 1; arm_cfg(1'b0);
    m = 8'h00; chg = 10; arm_cfg(1'b0);
    bus.itxTrigger = 1'b1;
    tick();
    check("reject_no_fire", 32'(bus.otxBusy), 32'd0);
    bus.itxTrigger = 1'b0;
    tick();
    m = 8'h03; chg = MAX_ON; bst = 0; per = 0; ph[0] = 2; ph[1] = 0;
    arm_cfg(1'b1);
    fire(0, 1'b0);

    // Trigger already high at arm; arm beats a same-cycle trigger edge.
    m = 8'h02; chg = 3; bst = 2; per = 5; ph[1] = 1;
    bus.itxTrigger = 1'b1;
    arm_cfg(1'b1);
    tick();
    check("held_trig_busy", 32'(bus.otxBusy), 32'd0);
    check("held_trig_armed", 32'(bus.otxArmed), 32'd1);
    bus.itxTrigger = 1'b0;
    tick();
    bus.itxArm = 1'b1;
    bus.itxTrigger = 1'b1;
    tick();
    bus.itxArm = 1'b0;
    check("arm_vs_edge_busy", 32'(bus.otxBusy), 32'd0);
    check("arm_vs_edge_armed", 32'(bus.otxArmed), 32'd1);
    tick();
    check("no_edge_busy", 32'(bus.otxBusy), 32'd0);
    bus.itxTrigger = 1'b0;
    tick();
    fire(0, 1'b0);

    // Abort while armed, then abort mid-pulse.
    m = 8'h01; chg = 10; bst = 1; per = 0; ph[0] = 0;
    arm_cfg(1'b1);
    bus.itxAbort = 1'b1;
    tick();
    bus.itxAbort = 1'b0;
    check("abort_armed", 32'(bus.otxArmed), 32'd0);
    bus.itxTrigger = 1'b1;
    tick();
    check("abort_armed_no_fire", 32'(bus.otxBusy), 32'd0);
    bus.itxTrigger = 1'b0;
    tick();
    arm_cfg(1'b1);
    fire(3, 1'b0);

    // Watchdog expiry.
    m = 8'h01; chg = 10; bst = 1; per = 0; ph[0] = 100;
    arm_cfg(1'b1);
    fire(0, 1'b0);

    // Randomized configurations.
    for (int i = 0; i < 25; i++) begin
      m   = NCH'($urandom_range(1, 255));
      chg = $urandom_range(1, 12);
      bst = $urandom_range(0, 4);
      per = $urandom_range(0, 20);
      for (int k = 0; k < NCH; k++) ph[k] = $urandom_range(0, 20);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) chg = 0; else m = '0;
        arm_cfg(1'b0);
        bus.itxTrigger = 1'b1;
        tick();
        check("rand_reject_busy", 32'(bus.otxBusy), 32'd0);
        bus.itxTrigger = 1'b0;
        tick();
      end else begin
        arm_cfg(1'b1);
        fire(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0, 1'b1);
      end
    end

    // Reset in the middle of a burst drops the drive immediately.
    m = 8'hFF; chg = 10; bst = 2; per = 20;
    for (int k = 0; k < NCH; k++) ph[k] = 0;
    arm_cfg(1'b1);
    bus.itxTrigger = 1'b1;
    tick();
    bus.itxTrigger = 1'b0;
    tick();
    tick();
    check("pre_reset_out", 32'(bus.otxTransducerOutput), 32'(model_out(3)));
    rst_n = 1'b0;
    #1;
    check("async_reset_out", 32'(bus.otxTransducerOutput), 32'd0);
    check("async_reset_busy", 32'(bus.otxBusy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_armed", 32'(bus.otxArmed), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
